seg7_scan_capture: RTL and testbench

//  Bus-side reader for the multiplexed 7-segment display interface (AN/SEG, both active-low).
//  It samples a scanned display bus and turns each digit's segment pattern back into a hex nibble.
//  It assembles a full frame of N_DIGITS nibbles into a packed value with a frame-valid pulse.

---
 rtl/seg7_scan_capture.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Reads a scanned, active-low 7-segment bus back into hex nibbles and publishes whole frames.
// Optional SEG7_CAP_DP_EN: capture the decimal point of each digit into dp_mask.
module seg7_scan_capture #(
    parameter int unsigned N_DIGITS      = 8,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN_in,
    input  logic [7:0]  SEG_in,
    input  logic        clear,
    output logic [31:0] value,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic [2:0]  err_digit,
    output logic        bus_idle
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntHit = CntW'(STABLE_CYCLES - 1);
    localparam logic [7:0] AnMask = 8'((16'd1 << N_DIGITS) - 16'd1);
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    localparam logic [N_DIGITS-1:0] SeenAll = '1;
`ifdef SEG7_CAP_DP_EN
    localparam logic [7:0] SegMask = 8'hFF;
`else
    localparam logic [7:0] SegMask = 8'h7F;
`endif

    typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_e;

    logic [7:0]          an_s1, an_s2, seg_s1, seg_s2;
    logic [CntW-1:0]     cnt_q;
    logic                changed, accept, wr_ok, err_acc, dec_ok, blank, publish, frame_full;
    logic [N_DIGITS-1:0] act, seen_q, seen_d, seen_base, seen_wr;
    logic [2:0]          idx;
    logic [3:0]          nib;
    logic [15:0]         tmo_q, tmo_d;
    logic [31:0]         shadow_q;
    state_e              state_q, state_d;

    // Stage-1 vs stage-2 compare: cnt_q tracks how long the current synced sample has held.
    assign changed = (|((an_s1 ^ an_s2) & AnMask)) | (|((seg_s1 ^ seg_s2) & SegMask));
    assign act     = ~an_s2[N_DIGITS-1:0];
    assign accept  = (cnt_q == CntHit) && $onehot(act);
    assign wr_ok   = accept && (dec_ok || blank);
    assign err_acc = accept && !(dec_ok || blank);
    assign bus_idle = (state_q == StIdle);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (act[i]) idx = 3'(i);
        end
    end

    always_comb begin
        nib    = 4'h0;
        dec_ok = 1'b1;
        blank  = 1'b0;
        case (seg_s2[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h18: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h7F: begin dec_ok = 1'b0; blank = 1'b1; end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        publish    = 1'b0;
        seen_base  = (state_q == StPublish) ? '0 : seen_q;
        seen_wr    = seen_base | (wr_ok ? act : '0);
        seen_d     = seen_wr;
        frame_full = wr_ok && (seen_wr == SeenAll);
        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (wr_ok) state_d = frame_full ? StPublish : StCollect;
            end
            StCollect: begin
                if (accept) begin
                    tmo_d = '0;
                    if (frame_full) state_d = StPublish;
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                    seen_d  = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StPublish: begin
                publish = 1'b1;
                tmo_d   = '0;
                state_d = frame_full ? StPublish : StCollect;
            end
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
            seen_d  = '0;
            tmo_d   = '0;
            publish = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_s1       <= 8'hFF;
            an_s2       <= 8'hFF;
            seg_s1      <= 8'hFF;
            seg_s2      <= 8'hFF;
            cnt_q       <= '0;
            state_q     <= StIdle;
            seen_q      <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            err_digit   <= '0;
        end else begin
            an_s1       <= AN_in;
            an_s2       <= an_s1;
            seg_s1      <= SEG_in;
            seg_s2      <= seg_s1;
            cnt_q       <= changed ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1));
            state_q     <= state_d;
            seen_q      <= seen_d;
            tmo_q       <= tmo_d;
            frame_valid <= publish;
            if (publish) value <= shadow_q;
            if (wr_ok && !clear) shadow_q[{idx, 2'b00} +: 4] <= nib;
            if (clear) begin
                pattern_err <= 1'b0;
            end else if (err_acc) begin
                pattern_err <= 1'b1;
                err_digit   <= idx;
            end
        end
    end

`ifdef SEG7_CAP_DP_EN
    logic [7:0] dp_shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_mask     <= '0;
        end else begin
            if (wr_ok && !clear) dp_shadow_q[idx] <= ~seg_s2[7];
            if (publish) dp_mask <= dp_shadow_q;
        end
    end
`else
    assign dp_mask = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans frames onto the bus and scoreboards published values.
module tb_seg7_scan_capture;

    localparam int unsigned Timeout = 200;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [7:0]  AN_in, SEG_in;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic        frame_valid, pattern_err, bus_idle;
    logic [2:0]  err_digit;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  dp;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         frames = 0;
    int         exp_frames = 0;
    int         n;
    logic [7:0] segs [8];

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .N_DIGITS      (8),
        .STABLE_CYCLES (16),
        .TIMEOUT       (Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .AN_in       (AN_in),
        .SEG_in      (SEG_in),
        .clear       (clear),
        .value       (value),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .err_digit   (err_digit),
        .bus_idle    (bus_idle)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] dp_exp(input logic [7:0] dp);
`ifdef SEG7_CAP_DP_EN
        return dp;
`else
        return 8'h00;
`endif
    endfunction

    task automatic fill(input logic [31:0] val, input logic [7:0] dp);
        for (int i = 0; i < 8; i++) segs[i] = {~dp[i], hex_seg(val[4*i +: 4])};
    endtask

    task automatic push(input logic [31:0] val, input logic [7:0] dp);
        exp_t e;
        e.v  = val;
        e.dp = dp_exp(dp);
        exp_q.push_back(e);
        exp_frames++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic show(input int i, input logic [7:0] seg);
        @(negedge clk);
        AN_in  = ~(8'h01 << i);
        SEG_in = seg;
    endtask

    task automatic scan(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            show(i, segs[i]);
            repeat (31) @(negedge clk);
        end
    endtask

    task automatic idle_bus(input int cycles);
        @(negedge clk);
        AN_in  = 8'hFF;
        SEG_in = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && frame_valid === 1'b1) begin
            frames++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_frame observed=%0h expected=none", value);
            end else begin
                e = exp_q.pop_front();
                check("frame_value", value, e.v);
                check("frame_dp", {24'd0, dp_mask}, {24'd0, e.dp});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        clear  = 1'b0;
        AN_in  = 8'hFF;
        SEG_in = 8'hFF;
        repeat (4) @(negedge clk);
        check("rst_value", value, 32'h0);
        check("rst_dp", {24'd0, dp_mask}, 32'h0);
        check("rst_fv", {31'd0, frame_valid}, 32'h0);
        check("rst_perr", {31'd0, pattern_err}, 32'h0);
        check("rst_errdig", {29'd0, err_digit}, 32'h0);
        check("rst_idle", {31'd0, bus_idle}, 32'h1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Full frame, with latency measured on the final digit
        fill(32'h1234ABCD, 8'h00);
        push(32'h1234ABCD, 8'h00);
        scan(0, 6);
        show(7, segs[7]);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n++;
            if (frame_valid === 1'b1) break;
        end
        check("latency", 32'(n), 32'd19);
        repeat (15) @(negedge clk);
        idle_bus(10);
        check("t1_frames", 32'(frames), 32'(exp_frames));
        check("t1_value", value, 32'h1234ABCD);
        check("t1_perr", {31'd0, pattern_err}, 32'h0);
        check("t1_collect", {31'd0, bus_idle}, 32'h0);

        // Decimal points on digits 0 and 7
        fill(32'h1234ABCD, 8'h81);
        push(32'h1234ABCD, 8'h81);
        scan(0, 7);
        idle_bus(10);
        check("t6_dp", {24'd0, dp_mask}, {24'd0, dp_exp(8'h81)});

        // Blank digit 3 still completes the frame
        fill(32'h89ABCDEF, 8'h00);
        segs[3] = 8'hFF;
        push(32'h89AB0DEF, 8'h00);
        scan(0, 7);
        idle_bus(10);
        check("t2_blank_value", value, 32'h89AB0DEF);
        check("t2_blank_perr", {31'd0, pattern_err}, 32'h0);

        // Undecodable digit 5 blocks the frame and flags the error
        fill(32'h76543210, 8'h00);
        segs[5] = 8'hAA;
        scan(0, 7);
        idle_bus(10);
        check("t2_err_perr", {31'd0, pattern_err}, 32'h1);
        check("t2_err_digit", {29'd0, err_digit}, 32'd5);
        check("t2_err_frames", 32'(frames), 32'(exp_frames));
        check("t2_err_value", value, 32'h89AB0DEF);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("t2_clr_perr", {31'd0, pattern_err}, 32'h0);
        check("t2_clr_idle", {31'd0, bus_idle}, 32'h1);

        // Short glitch on digit 4 must not be accepted
        fill(32'h5A6B7C8D, 8'h00);
        push(32'h5A6B7C8D, 8'h00);
        scan(0, 3);
        show(4, segs[4]);
        repeat (7) @(negedge clk);
        @(negedge clk) SEG_in = {1'b1, 7'h06};
        repeat (9) @(negedge clk);
        @(negedge clk) SEG_in = segs[4];
        repeat (31) @(negedge clk);
        scan(5, 7);
        idle_bus(10);
        check("t3_value", value, 32'h5A6B7C8D);
        check("t3_frames", 32'(frames), 32'(exp_frames));

        // Partial scan times out back to idle, then a full scan publishes
        fill(32'hCAFE0123, 8'h00);
        scan(0, 4);
        idle_bus(0);
        check("t4_busy", {31'd0, bus_idle}, 32'h0);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n++;
            if (bus_idle === 1'b1) break;
        end
        check("t4_window", {31'd0, (n >= 150 && n <= 220)}, 32'h1);
        check("t4_value_kept", value, 32'h5A6B7C8D);
        check("t4_no_frame", 32'(frames), 32'(exp_frames));
        push(32'hCAFE0123, 8'h00);
        scan(0, 7);
        idle_bus(10);
        check("t4_restart", value, 32'hCAFE0123);

        // clear coincident with the final accept
        show(5, 8'hAA);
        repeat (31) @(negedge clk);
        check("t5_perr_set", {31'd0, pattern_err}, 32'h1);
        fill(32'h0BADF00D, 8'h00);
        scan(0, 6);
        show(7, segs[7]);
        repeat (17) @(posedge clk);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("t5_idle", {31'd0, bus_idle}, 32'h1);
        check("t5_perr", {31'd0, pattern_err}, 32'h0);
        repeat (30) @(negedge clk);
        check("t5_still_idle", {31'd0, bus_idle}, 32'h1);
        idle_bus(10);
        check("t5_no_frame", 32'(frames), 32'(exp_frames));
        check("t5_value_kept", value, 32'hCAFE0123);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
